// File: rtl/freq_pkg.sv
// Shared definitions for the frequency-count to BCD conversion path.
package freq_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int DIGITS_DEF  = 10;
  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/freq_bcd_digit.sv
// One double-dabble correction cell: a digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decade.
module freq_bcd_digit
  import freq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  // add-3 correction for digits that would overflow past 9 after the shift
  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/freq_bcd_conv.sv
// Sequential double-dabble converter: binary count in, packed BCD digits and
// a leading-zero blank mask out. One shift/add-3 step per clock. Conversion
// restarts whenever the input differs from the last converted value or on a
// request strobe; a request arriving mid-conversion is remembered.
module freq_bcd_conv
  import freq_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                          clk,
  input  logic                          RST,
  input  logic [WIDTH-1:0]              data_in,
  input  logic                          conv_req,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic [DIGITS-1:0]             blank_mask,
  output logic                          bcd_valid,
  output logic                          busy
);

  localparam int ACC_W      = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W      = $clog2(WIDTH + 1);
  // ceil(WIDTH * log10(2)) in integer arithmetic
  localparam int MIN_DIGITS = (WIDTH * 30103 + 99999) / 100000;

  if (DIGITS < MIN_DIGITS) begin : g_digits_check
    $error("freq_bcd_conv: DIGITS too small for WIDTH");
  end

  state_t                   state_reg;
  state_t                   state_next;
  logic [WIDTH-1:0]         last_val_reg;
  logic [WIDTH-1:0]         bin_reg;
  logic [ACC_W-1:0]         acc_reg;
  logic [ACC_W-1:0]         acc_adj;
  logic [CNT_W-1:0]         cnt_reg;
  logic                     pending_reg;
  logic [ACC_W-1:0]         bcd_out_reg;
  logic [DIGITS-1:0]        blank_mask_reg;
  logic                     bcd_valid_reg;
  logic [DIGITS-1:0]        blank_calc;
  logic                     trigger;
  logic                     last_step;

  assign trigger   = (data_in != last_val_reg) || conv_req || pending_reg;
  assign last_step = (cnt_reg == CNT_W'(WIDTH - 1));

  // Per-digit add-3 cells and the leading-zero mask: digit k blanks when it
  // and every more significant digit are zero; digit 0 is never blanked.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    freq_bcd_digit u_digit (
      .din  (acc_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (acc_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
    if (gi == 0) begin : g_lsd
      assign blank_calc[gi] = 1'b0;
    end else begin : g_upper
      assign blank_calc[gi] = (acc_reg[ACC_W-1:gi*BCD_DIGIT_W] == '0);
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (trigger) state_next = SHIFT;
      SHIFT:   if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // busy covers every non-idle cycle, i.e. SHIFT through DONE
  always_comb begin
    busy = (state_reg != IDLE);
  end

  // conversion datapath and registered results
  always_ff @(posedge clk) begin
    if (RST) begin
      last_val_reg   <= '0;
      bin_reg        <= '0;
      acc_reg        <= '0;
      cnt_reg        <= '0;
      pending_reg    <= 1'b0;
      bcd_out_reg    <= '0;
      blank_mask_reg <= {{(DIGITS-1){1'b1}}, 1'b0};
      bcd_valid_reg  <= 1'b0;
    end else begin
      bcd_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (trigger) begin
            bin_reg      <= data_in;
            last_val_reg <= data_in;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            pending_reg  <= 1'b0;
          end
        end
        SHIFT: begin
          {acc_reg, bin_reg} <= {acc_adj, bin_reg} << 1;
          cnt_reg            <= cnt_reg + 1'b1;
          if (conv_req) pending_reg <= 1'b1;
        end
        DONE: begin
          bcd_out_reg    <= acc_reg;
          blank_mask_reg <= blank_calc;
          bcd_valid_reg  <= 1'b1;
          if (conv_req) pending_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bcd_out    = bcd_out_reg;
  assign blank_mask = blank_mask_reg;
  assign bcd_valid  = bcd_valid_reg;

endmodule

// File: tb/tb_freq_bcd_conv.sv
// Directed bench for freq_bcd_conv: a table of conversions with hand-computed
// BCD and blank masks, plus sequences for mid-conversion changes, reset abort
// and reconversion requests.
module tb_freq_bcd_conv;

  logic        clk = 1'b0;
  logic        RST;
  logic [31:0] data_in;
  logic        conv_req;
  logic [39:0] bcd_out;
  logic [9:0]  blank_mask;
  logic        bcd_valid;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  localparam logic [9:0] MASK_RST = 10'b1111111110;

  typedef struct {
    logic [31:0] din;
    logic [39:0] bcd;
    logic [9:0]  mask;
  } vec_t;

  vec_t vecs [8];

  freq_bcd_conv #(.WIDTH(32), .DIGITS(10)) dut (
    .clk        (clk),
    .RST        (RST),
    .data_in    (data_in),
    .conv_req   (conv_req),
    .bcd_out    (bcd_out),
    .blank_mask (blank_mask),
    .bcd_valid  (bcd_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts rising edges from the current negedge until bcd_valid is seen.
  // conv_req is dropped after one edge. At edge 10 the held output is checked.
  task automatic wait_valid(input logic [39:0] prev_bcd, output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      conv_req = 1'b0;
      if (n == 10) begin
        check("busy_mid", 64'(busy), 64'd1);
        check("hold_mid", 64'(bcd_out), 64'(prev_bcd));
      end
      if (bcd_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic expect_result(input string name, input int lat,
                               input logic [39:0] bcd, input logic [9:0] mask);
    $display("%s: din=%0d lat=%0d bcd=%h mask=%b", name, data_in, lat, bcd_out, blank_mask);
    check({name, "_lat"}, 64'(lat), 64'd34);
    check({name, "_bcd"}, 64'(bcd_out), 64'(bcd));
    check({name, "_mask"}, 64'(blank_mask), 64'(mask));
    check({name, "_busy_at_valid"}, 64'(busy), 64'd0);
    @(negedge clk);
    check({name, "_pulse_len"}, 64'(bcd_valid), 64'd0);
  endtask

  // Expect no valid pulse for n cycles.
  task automatic quiet(input string name, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bcd_valid) seen++;
    end
    check(name, 64'(seen), 64'd0);
  endtask

  initial begin
    int lat;
    int seen;
    logic [39:0] prev;

    vecs[0] = '{32'd1000,       40'h00_0000_1000, 10'b1111110000};
    vecs[1] = '{32'hFFFF_FFFF,  40'h42_9496_7295, 10'b0000000000};
    vecs[2] = '{32'd42,         40'h00_0000_0042, 10'b1111111100};
    vecs[3] = '{32'd7,          40'h00_0000_0007, 10'b1111111110};
    vecs[4] = '{32'd0,          40'h00_0000_0000, 10'b1111111110};
    vecs[5] = '{32'd100000000,  40'h01_0000_0000, 10'b1000000000};
    vecs[6] = '{32'd1000000000, 40'h10_0000_0000, 10'b0000000000};
    vecs[7] = '{32'd12345,      40'h00_0001_2345, 10'b1111100000};

    // reset
    RST = 1'b1; data_in = '0; conv_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bcd", 64'(bcd_out), 64'd0);
    check("rst_mask", 64'(blank_mask), 64'(MASK_RST));
    check("rst_valid", 64'(bcd_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    RST = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bcd_valid || busy) seen++;
    end
    check("idle_zero_no_activity", 64'(seen), 64'd0);
    check("idle_bcd", 64'(bcd_out), 64'd0);
    check("idle_mask", 64'(blank_mask), 64'(MASK_RST));

    // table of conversions
    prev = 40'h0;
    for (int v = 0; v < 8; v++) begin
      data_in = vecs[v].din;
      wait_valid(prev, lat);
      expect_result($sformatf("vec%0d", v), lat, vecs[v].bcd, vecs[v].mask);
      prev = vecs[v].bcd;
      repeat (3) @(negedge clk);
    end
    quiet("table_no_extra", 20);

    // input changes while busy: 12345 then 678 then 999
    data_in = 32'd11;
    wait_valid(prev, lat);
    expect_result("pre11", lat, 40'h11, 10'b1111111100);
    data_in = 32'd12345;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 5)  data_in = 32'd678;
      if (n == 15) data_in = 32'd999;
      if (bcd_valid) begin
        lat = n;
        break;
      end
    end
    expect_result("busy_first", lat, 40'h1_2345, 10'b1111100000);
    // the pulse check consumed one cycle of the 34
    lat = -1;
    for (int n = 2; n <= 200; n++) begin
      @(negedge clk);
      if (bcd_valid) begin
        lat = n;
        break;
      end
    end
    expect_result("busy_second", lat, 40'h999, 10'b1111111000);
    quiet("busy_no_678", 50);

    // reset during a conversion
    data_in = 32'd5555;
    repeat (10) @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    check("abort_bcd", 64'(bcd_out), 64'd0);
    check("abort_mask", 64'(blank_mask), 64'(MASK_RST));
    check("abort_valid", 64'(bcd_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    RST = 1'b0;
    wait_valid(40'h0, lat);
    expect_result("after_abort", lat, 40'h5555, 10'b1111110000);

    // reconversion requests with data_in unchanged
    data_in = 32'd42;
    wait_valid(40'h5555, lat);
    expect_result("set42", lat, 40'h42, 10'b1111111100);
    quiet("set42_quiet", 10);
    conv_req = 1'b1;
    wait_valid(40'h42, lat);
    expect_result("req1", lat, 40'h42, 10'b1111111100);
    quiet("req1_single", 50);

    // second request while busy gives exactly one extra pulse
    conv_req = 1'b1;
    @(negedge clk);
    conv_req = 1'b0;
    repeat (4) @(negedge clk);
    conv_req = 1'b1;
    seen = 0;
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      conv_req = 1'b0;
      if (bcd_valid) seen++;
    end
    $display("req_while_busy: pulses=%0d bcd=%h", seen, bcd_out);
    check("req_busy_pulses", 64'(seen), 64'd2);
    check("req_busy_bcd", 64'(bcd_out), 64'h42);

    // request coincident with a change: one conversion only
    data_in = 32'd43;
    conv_req = 1'b1;
    wait_valid(40'h42, lat);
    expect_result("req_and_change", lat, 40'h43, 10'b1111111100);
    quiet("req_and_change_single", 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_bcd_conv.md
Name: freq_bcd_conv

Overview:
- Downstream of the frequency counter. Takes its 32-bit gated count and converts it to packed BCD digits for the seven-segment display controller.
- Conversion is sequential double-dabble: one shift/add-3 step per clock.
- A new conversion starts automatically whenever the input count changes, or on an explicit request.
- Also produces a leading-zero blank mask so the display stage can suppress unused digits.

Parameters:
- WIDTH, 32, binary input width.
- DIGITS, 10, number of BCD output digits. Must satisfy DIGITS >= ceil(WIDTH*log10(2)); an elaboration-time check fails otherwise.

Ports:
- clk  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- data_in  in  WIDTH  binary count from the frequency counter; may change at any cycle, with no valid qualifier.
- conv_req  in  1  single-cycle strobe; forces reconversion of the current data_in even if it is unchanged.
- bcd_out  out  4*DIGITS  packed BCD; digit k occupies bits [4k+3:4k], with digit 0 the least significant.
- blank_mask  out  DIGITS  bit k=1 means digit k is a leading zero; bit 0 is always 0.
- bcd_valid  out  1  one-cycle pulse when bcd_out/blank_mask update.
- busy  out  1  high while a conversion is in progress.

Behaviour:
- Everything is clocked on the rising edge of clk. RST is checked before all other logic.
- Reset values:
  - bcd_out=0.
  - blank_mask = all ones except bit 0 (displays "0").
  - bcd_valid=0, busy=0.
  - last_val=0, pending=0, state=IDLE.
- Internal state: last_val (WIDTH), bin shift register (WIDTH), bcd accumulator (4*DIGITS), step counter (clog2(WIDTH+1) bits), pending flag.
- Trigger = (data_in != last_val) OR conv_req OR pending, evaluated only in IDLE.
- IDLE:
  - On trigger: bin<=data_in, last_val<=data_in, acc<=0, cnt<=0, pending<=0, busy<=1, go to SHIFT.
  - No trigger: hold.
- SHIFT, each cycle:
  - Every acc digit >= 5 gets +3.
  - Then {acc,bin} is shifted left by 1.
  - cnt increments.
  - When cnt reaches WIDTH-1 this cycle, go to DONE.
- DONE:
  - bcd_out<=acc.
  - blank_mask computed from acc: bit k=1 iff digits k..DIGITS-1 are all zero and k>0.
  - bcd_valid<=1 for exactly one cycle; busy<=0; go to IDLE.
- Latency: data_in change sampled at edge E0; bcd_valid is high in the cycle following edge E0+WIDTH+1 (34 clocks for WIDTH=32). Back-to-back conversions therefore take WIDTH+2 cycles each.
- busy is 1 from the cycle after the trigger edge through the DONE cycle. bcd_valid and busy never assert together after DONE.
- data_in changes while busy are not sampled. On return to IDLE, the data_in != last_val comparison restarts conversion, so the newest value is always converted and intermediate values are dropped.
- conv_req while busy sets pending; pending triggers one more conversion from IDLE.
- conv_req in IDLE coincident with a data_in change produces a single conversion.
- bcd_out holds its last result during a conversion; no partial values are ever visible.
- RST mid-conversion aborts immediately and all outputs return to reset values. last_val=0, so a nonzero data_in retriggers after reset is released.
- data_in = 0 after reset: no conversion occurs (it equals last_val); outputs already show "0".

Decomposition:
- Shared package freq_pkg holds:
  - default WIDTH=32, DIGITS=10;
  - state enum {IDLE, SHIFT, DONE};
  - a BCD_DIGIT_W=4 constant.
- One natural sub-module: freq_bcd_digit, a combinational per-digit add-3 correction cell, instantiated DIGITS times via generate.

Test Plan:
- Reset check: assert RST 3 cycles, then release with data_in=0. Required: bcd_out=0, blank_mask=10'b1111111110, no bcd_valid for 100 cycles.
- Basic conversion: data_in=1000 (0x3E8). Required: bcd_valid exactly 34 cycles after the change, bcd_out=40'h00_0000_1000, blank_mask=10'b1111110000.
- Maximum value: data_in=0xFFFF_FFFF. Required: bcd_out=40'h42_9496_7295, blank_mask=0.
- Change during busy: data_in=12345, then 678 five cycles later, then 999 ten cycles later. Required:
  - first valid shows 12345;
  - second valid, 34 cycles after the first DONE+1, shows 999;
  - 678 is never output.
- Reset mid-conversion: RST pulse 10 cycles into converting 5555. Required:
  - outputs at reset values;
  - after release, reconversion gives 5555 after 34 cycles.
- Reconversion request: conv_req with data_in unchanged at 42. Required: one valid pulse, bcd_out=...0042, blank_mask=10'b1111111100. A second conv_req issued while busy yields exactly one extra pulse.
